// File: rtl/fp_pkg.sv
// Shared definitions for the FP post-normalise/round slice: rounding modes,
// flag bit positions and the leading-zero-count width helper.
package fp_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_t;

  localparam int FLAG_W    = 4;
  localparam int FLAG_OVF  = 3;
  localparam int FLAG_UNF  = 2;
  localparam int FLAG_INX  = 1;
  localparam int FLAG_ZERO = 0;

  // Bits needed to hold a count of 0..n inclusive.
  function automatic int lzc_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fp_postnorm_round_if.sv
// Upstream (unrounded result) and downstream (packed result) valid/ready
// streams of the post-normalise/round stage, grouped as one bundle.
interface fp_postnorm_round_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  import fp_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic [EXP_W:0]         in_exp;
  logic [MAN_W+4:0]       in_mant;
  rm_t                    round_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_result;
  logic [FLAG_W-1:0]      out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, round_mode, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, round_mode, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; returns W when the input is all zero.
// No state, no handshake.
module fp_lzc
  import fp_pkg::*;
#(
  parameter int W = 25
) (
  input  logic [W-1:0]          din,
  output logic [lzc_w(W)-1:0]   cnt
);

  localparam int CW = lzc_w(W);

  // Scan upward so the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_postnorm_round.sv
// Normalise (S1) then round/pack (S2) an unrounded FP result; 2-cycle latency,
// one result per cycle, stages stall in place when out_ready is low.
module fp_postnorm_round
  import fp_pkg::*;
#(
  parameter int EXP_W        = 8,
  parameter int MAN_W        = 23,
  parameter int FLUSH_DENORM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_postnorm_round_if.slave bus
);

  localparam int MW = MAN_W + 4;            // {hidden, fraction, G, R, S}
  localparam int EW = EXP_W + 3;            // room for negative exponents
  localparam int CW = lzc_w(MAN_W + 2);
  localparam int SW = lzc_w(MAN_W + 3);
  localparam logic [EW-1:0] E_OVF = EW'((1 << EXP_W) - 1);

  logic                 in_rdy;
  logic                 s2_adv;

  logic                 s1_valid;
  logic                 s1_sign;
  rm_t                  s1_rm;
  logic [EW-1:0]        s1_e;
  logic [MW-1:0]        s1_m;
  logic                 s1_flush;
  logic                 s1_tiny;

  logic                 s2_valid;
  logic [EXP_W+MAN_W:0] s2_res;
  logic [FLAG_W-1:0]    s2_flags;

  assign s2_adv = !s2_valid || bus.out_ready;
  assign in_rdy = !s1_valid || s2_adv;

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = s2_valid;
  assign bus.out_result = s2_res;
  assign bus.out_flags  = s2_flags;

  // ---------------- S1: normalise ----------------
  logic [MW-1:0] m_in;
  logic          carry;
  logic [CW-1:0] lz;
  logic [SW-1:0] sh;
  logic [EW-1:0] e_in, n_e, d, dc, nx_e;
  logic [MW-1:0] n_m, den_m, nx_m;
  logic          n_zero, tiny, nx_flush;

  assign m_in  = bus.in_mant[MW-1:0];
  assign carry = bus.in_mant[MW];

  fp_lzc #(.W(MAN_W + 2)) u_lzc (
    .din (m_in[MW-1:2]),
    .cnt (lz)
  );

  always_comb begin
    // Only R or S left below the counted window: shift them up to hidden.
    sh = SW'(lz);
    if (lz == CW'(MAN_W + 2)) sh = m_in[1] ? SW'(MAN_W + 2) : SW'(MAN_W + 3);

    e_in   = {2'b00, bus.in_exp};
    n_m    = m_in;
    n_e    = e_in;
    n_zero = 1'b0;
    if (carry) begin
      n_m = {bus.in_mant[MW:2], |bus.in_mant[1:0]};
      n_e = e_in + EW'(1);
    end else if (!m_in[MW-1]) begin
      if (|m_in) begin
        n_m = m_in << sh;
        n_e = e_in - EW'(sh);
      end else begin
        n_m    = '0;
        n_e    = '0;
        n_zero = 1'b1;
      end
    end

    tiny     = !n_zero && (n_e[EW-1] || (n_e == '0));
    nx_flush = tiny && (FLUSH_DENORM != 0);

    // Gradual underflow: denormalise to exponent 1 with hidden bit cleared.
    d        = EW'(1) - n_e;
    dc       = (d > EW'(MW)) ? EW'(MW) : d;
    den_m    = n_m >> dc;
    den_m[0] = den_m[0] | (|(n_m & ~({MW{1'b1}} << dc)));

    nx_m = n_m;
    nx_e = n_e;
    if (nx_flush) begin
      nx_m = '0;
      nx_e = '0;
    end else if (tiny) begin
      nx_m = den_m;
      nx_e = EW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_rm    <= RM_RNE;
      s1_e     <= '0;
      s1_m     <= '0;
      s1_flush <= 1'b0;
      s1_tiny  <= 1'b0;
    end else if (in_rdy) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign  <= bus.in_sign;
        s1_rm    <= bus.round_mode;
        s1_e     <= nx_e;
        s1_m     <= nx_m;
        s1_flush <= nx_flush;
        s1_tiny  <= tiny;
      end
    end
  end

  // ---------------- S2: round and pack ----------------
  logic [MAN_W:0]     sig;
  logic [MAN_W+1:0]   sum;
  logic               g, r, st, inx, inc, ovf, to_inf;
  logic [EW-1:0]      e_fin;
  logic [EXP_W-1:0]   r_exp;
  logic [MAN_W-1:0]   r_frac;
  logic [FLAG_W-1:0]  r_flags;

  always_comb begin
    sig = s1_m[MW-1:3];
    g   = s1_m[2];
    r   = s1_m[1];
    st  = s1_m[0];
    inx = g | r | st;

    inc = 1'b0;
    case (s1_rm)
      RM_RNE: inc = g & (r | st | sig[0]);
      RM_RTZ: inc = 1'b0;
      RM_RUP: inc = !s1_sign & inx;
      RM_RDN: inc = s1_sign & inx;
    endcase

    // Exponent field follows the hidden bit, so a subnormal that rounds up
    // into the hidden position becomes the smallest normal.
    sum = {1'b0, sig} + (MAN_W + 2)'(inc);
    if (sum[MAN_W+1]) begin
      e_fin  = s1_e + EW'(1);
      r_frac = '0;
    end else begin
      e_fin  = sum[MAN_W] ? s1_e : '0;
      r_frac = sum[MAN_W-1:0];
    end

    ovf    = (e_fin >= E_OVF);
    to_inf = (s1_rm == RM_RNE) || (s1_rm == RM_RUP && !s1_sign) ||
             (s1_rm == RM_RDN && s1_sign);
    r_exp  = e_fin[EXP_W-1:0];
    if (ovf) begin
      r_exp  = to_inf ? '1 : {{(EXP_W-1){1'b1}}, 1'b0};
      r_frac = to_inf ? '0 : '1;
    end

    r_flags            = '0;
    r_flags[FLAG_OVF]  = ovf;
    r_flags[FLAG_UNF]  = s1_tiny & inx;
    r_flags[FLAG_INX]  = inx | ovf;
    r_flags[FLAG_ZERO] = (r_exp == '0) && (r_frac == '0);

    if (s1_flush) begin
      r_exp              = '0;
      r_frac             = '0;
      r_flags            = '0;
      r_flags[FLAG_UNF]  = 1'b1;
      r_flags[FLAG_INX]  = 1'b1;
      r_flags[FLAG_ZERO] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_flags <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res   <= {s1_sign, r_exp, r_frac};
        s2_flags <= r_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_postnorm_round.sv
// Directed known answers plus randomised traffic against a value-level model
// (leading-one position, integer remainder rounding) for fp_postnorm_round.
module tb_fp_postnorm_round;
  import fp_pkg::*;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fp_postnorm_round_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_postnorm_round #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FLUSH_DENORM(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;   // 0 ready, 1 random, 2 low on cycles 2-4, 3 never
  int          cyc_rel = 0;
  int          n_out = 0;
  bit          xfer, saw_stall, held_vld;
  logic [31:0] held_res;
  logic [3:0]  held_fl;
  bit          kat_en = 1'b0;
  logic [31:0] kat_res;
  logic [3:0]  kat_fl;

  // Value-level reference: locate the leading one, keep 24 bits, round the
  // integer remainder against half an ulp.
  function automatic exp_t model(input logic s, input logic [8:0] ex,
                                 input logic [27:0] m, input logic [1:0] rm);
    exp_t   o;
    longint mv, kept, rem, half;
    int     p, e, k;
    bit     inx, inc, to_inf;
    mv    = longint'(m);
    o.res = {s, 31'd0};
    o.fl  = 4'b0000;
    if (mv == 0) begin
      o.fl = 4'b0001;
      return o;
    end
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    e = int'(ex) + p - 26;
    if (e <= 0) begin
      o.fl = 4'b0111;
      return o;
    end
    k = p - 23;
    if (k > 0) begin
      kept = mv >> k;
      rem  = mv - (kept << k);
      half = longint'(1) << (k - 1);
    end else begin
      kept = mv << (-k);
      rem  = 0;
      half = 0;
    end
    inx = (rem != 0);
    case (rm)
      2'd0:    inc = inx && ((rem > half) || (rem == half && (kept % 2) == 1));
      2'd1:    inc = 1'b0;
      2'd2:    inc = inx && !s;
      default: inc = inx && s;
    endcase
    kept += longint'(inc);
    if (kept == (longint'(1) << 24)) begin
      kept = longint'(1) << 23;
      e    = e + 1;
    end
    if (e >= 255) begin
      to_inf = (rm == 2'd0) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
      o.res  = to_inf ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
      o.fl   = 4'b1010;
    end else begin
      o.res = {s, 8'(e), 23'(kept)};
      o.fl  = {2'b00, inx, 1'b0};
    end
    return o;
  endfunction

  function automatic logic [27:0] rand_mant();
    int          cls;
    int          pos;
    logic [27:0] r, msk;
    cls = $urandom_range(0, 6);
    r   = 28'($urandom);
    case (cls)
      0:       return {1'b1, r[26:0]};
      1, 2:    return {2'b01, r[25:0]};
      3: begin
        pos = $urandom_range(0, 25);
        msk = (28'd1 << pos) - 28'd1;
        return (28'd1 << pos) | (r & msk);
      end
      4:       return {2'b01, r[25:3], 3'b100};
      5:       return {2'b01, 23'h7FFFFF, r[2:0]};
      default: return ($urandom_range(0, 1) != 0) ? 28'd0 : {2'b01, r[25:4], 4'b1111};
    endcase
  endfunction

  function automatic logic [8:0] rand_exp();
    case ($urandom_range(0, 3))
      0, 1:    return 9'($urandom_range(1, 254));
      2:       return 9'($urandom_range(245, 270));
      default: return 9'($urandom_range(0, 30));
    endcase
  endfunction

  // One clock: sample at negedge, score outputs, record accepted inputs.
  task automatic cycle();
    exp_t e;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      2:       bus.out_ready = !(cyc_rel >= 1 && cyc_rel <= 3);
      default: bus.out_ready = 1'b0;
    endcase
    @(negedge clk);
    if (!bus.in_ready) saw_stall = 1'b1;
    if (held_vld && bus.out_valid) begin
      checks++;
      assert ({bus.out_result, bus.out_flags} === {held_res, held_fl}) else begin
        errors++;
        $error("FAIL hold_stable got %h/%b expected %h/%b",
               bus.out_result, bus.out_flags, held_res, held_fl);
      end
    end
    held_vld = bus.out_valid && !bus.out_ready;
    held_res = bus.out_result;
    held_fl  = bus.out_flags;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL spurious_out got %h expected no output", bus.out_result);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (bus.out_result === e.res) else begin
          errors++;
          $error("FAIL result got %h expected %h", bus.out_result, e.res);
        end
        checks++;
        assert (bus.out_flags === e.fl) else begin
          errors++;
          $error("FAIL flags got %b expected %b (result %h)", bus.out_flags, e.fl, e.res);
        end
      end
    end
    xfer = bus.in_valid && bus.in_ready;
    if (xfer) begin
      if (kat_en) exp_q.push_back({kat_res, kat_fl});
      else exp_q.push_back(model(bus.in_sign, bus.in_exp, bus.in_mant, bus.round_mode));
    end
    @(posedge clk);
    #1;
    cyc_rel++;
  endtask

  task automatic send(input logic s, input logic [8:0] ex, input logic [27:0] m,
                      input logic [1:0] rm);
    int guard;
    guard          = 0;
    bus.in_valid   = 1'b1;
    bus.in_sign    = s;
    bus.in_exp     = ex;
    bus.in_mant    = m;
    bus.round_mode = rm_t'(rm);
    do begin
      cycle();
      guard++;
    end while (!xfer && guard < 100);
    checks++;
    assert (xfer) else begin
      errors++;
      $error("FAIL accept_timeout in_ready stayed 0, expected accept within 100 cycles");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_kat(input logic s, input logic [8:0] ex, input logic [27:0] m,
                          input logic [1:0] rm, input logic [31:0] res, input logic [3:0] fl);
    kat_en  = 1'b1;
    kat_res = res;
    kat_fl  = fl;
    send(s, ex, m, rm);
    kat_en  = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    int g;
    g            = 0;
    bus.in_valid = 1'b0;
    while ((exp_q.size() != 0 || bus.out_valid) && g < 200) begin
      cycle();
      g++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain pending %0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, snap;
    bus.in_valid   = 1'b0;
    bus.in_sign    = 1'b0;
    bus.in_exp     = '0;
    bus.in_mant    = '0;
    bus.round_mode = RM_RNE;
    bus.out_ready  = 1'b1;
    rst_n          = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    assert (bus.out_valid === 1'b0) else begin errors++; $error("FAIL rst_out_valid got %b expected 0", bus.out_valid); end
    checks++;
    assert (bus.out_result === 32'h0) else begin errors++; $error("FAIL rst_out_result got %h expected 0", bus.out_result); end
    checks++;
    assert (bus.out_flags === 4'h0) else begin errors++; $error("FAIL rst_out_flags got %b expected 0", bus.out_flags); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    assert (bus.in_ready === 1'b1) else begin errors++; $error("FAIL rst_in_ready got %b expected 1", bus.in_ready); end

    // Known answers: ties, halfway-up, overflow, flush to zero, true zero.
    rdy_mode = 0;
    send_kat(1'b0, 9'd127, 28'h4000004, 2'd0, 32'h3F800000, 4'b0010);
    send_kat(1'b0, 9'd127, 28'h400000C, 2'd0, 32'h3F800002, 4'b0010);
    send_kat(1'b0, 9'd127, 28'h400000C, 2'd1, 32'h3F800001, 4'b0010);
    send_kat(1'b0, 9'd254, 28'h8000000, 2'd0, 32'h7F800000, 4'b1010);
    send_kat(1'b0, 9'd254, 28'h8000000, 2'd1, 32'h7F7FFFFF, 4'b1010);
    send_kat(1'b1, 9'd3,   28'h0200000, 2'd0, 32'h80000000, 4'b0111);
    send_kat(1'b0, 9'd3,   28'h0200000, 2'd2, 32'h00000000, 4'b0111);
    send_kat(1'b1, 9'd100, 28'h0000000, 2'd2, 32'h80000000, 4'b0001);
    send_kat(1'b1, 9'd127, 28'h4000004, 2'd3, 32'hBF800001, 4'b0010);
    drain();

    // Four back-to-back inputs with the sink stalled on cycles 2-4.
    rdy_mode  = 2;
    cyc_rel   = 0;
    saw_stall = 1'b0;
    n_out     = 0;
    for (int i = 0; i < 4; i++)
      send(1'($urandom_range(0, 1)), rand_exp(), rand_mant(), 2'($urandom_range(0, 3)));
    drain();
    checks++;
    assert (saw_stall === 1'b1) else begin errors++; $error("FAIL stall_in_ready got never-low expected low"); end
    checks++;
    assert (n_out == 4) else begin errors++; $error("FAIL burst_count got %0d expected 4", n_out); end

    // Random traffic with random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      send(1'($urandom_range(0, 1)), rand_exp(), rand_mant(), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 0;
    drain();

    // Reset with two results in flight.
    rdy_mode = 3;
    send(1'b0, 9'd130, 28'h4800000, 2'd0);
    send(1'b1, 9'd120, 28'h5000000, 2'd0);
    rst_n = 1'b0;
    #1;
    checks++;
    assert (bus.out_valid === 1'b0) else begin errors++; $error("FAIL midrst_out_valid got %b expected 0", bus.out_valid); end
    checks++;
    assert (bus.out_result === 32'h0) else begin errors++; $error("FAIL midrst_out_result got %h expected 0", bus.out_result); end
    exp_q.delete();
    held_vld = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_mode = 0;
    snap     = n_out;
    idle(5);
    checks++;
    assert (n_out == snap) else begin errors++; $error("FAIL post_reset_out got %0d outputs expected 0", n_out - snap); end

    send(1'b0, 9'd127, 28'h4000000, 2'd0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    checks++;
    assert (lat == 2) else begin errors++; $error("FAIL latency got %0d expected 2", lat); end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_postnorm_round.md
FP_POSTNORM_ROUND -- requirements
Module: fp_postnorm_round

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width.
REQ-003 SHALL have parameter FLUSH_DENORM, default 1, 1 = subnormal results flushed to signed zero.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream result valid.
REQ-007 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-008 SHALL have port in_sign  input  1  result sign.
REQ-009 SHALL have port in_exp  input  EXP_W+1  biased exponent with extra MSB (pre-normalization carry headroom).
REQ-010 SHALL have port in_mant  input  MAN_W+5  {carry, hidden, fraction[MAN_W], guard, round, sticky}.
REQ-011 SHALL have port round_mode  input  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf; sampled with the in_valid && in_ready transfer.
REQ-012 SHALL have port out_valid  output  1  packed result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts.
REQ-014 SHALL have port out_result  output  1+EXP_W+MAN_W  {sign, exponent, fraction}.
REQ-015 SHALL have port out_flags  output  4  {overflow, underflow, inexact, zero}.

Function
REQ-016 SHALL be a 2-stage pipeline: S1 normalize, S2 round and pack; latency exactly 2 cycles from input transfer to out_valid with no stall.
REQ-017 SHALL advance each stage when its output register is empty or downstream consumes it; in_ready = !s1_valid || s1_advance; full throughput one result per cycle.
REQ-018 SHALL hold out_result/out_flags stable while out_valid && !out_ready.
REQ-019 S1: carry=1 -> shift mantissa right 1, exponent+1, shifted-out bit ORed into sticky.
REQ-020 S1: carry=0, hidden=0, mantissa nonzero -> shift left by leading-zero count (lzc sub-module), exponent minus shift; guard/round/sticky shift in.
REQ-021 S1: whole mantissa zero -> zero result with in_sign preserved, exponent 0, flags zero=1, no rounding.
REQ-022 S1: exponent after left shift <= 0 -> underflow; FLUSH_DENORM=1 gives signed zero, flags underflow=1, inexact=1, zero=1.
REQ-023 S2 rounding increment: RNE = G && (R||S||LSB); RTZ = 0; +inf = !sign && (G||R||S); -inf = sign && (G||R||S); never decrement.
REQ-024 S2: inexact = G||R||S before rounding.
REQ-025 S2: increment carrying out of the fraction -> fraction 0, exponent+1.
REQ-026 S2: final exponent >= 2^EXP_W-1 -> overflow=1, inexact=1; RNE and sign-matching directed mode give infinity (exp all ones, fraction 0); RTZ and opposite directed mode give max finite (exp 2^EXP_W-2, fraction all ones).
REQ-027 SHALL treat simultaneous input accept and output consume in one cycle as both occurring, without a bubble.

Reset
REQ-028 rst_n low SHALL immediately clear s1_valid, s2_valid, out_valid to 0 and out_result, out_flags to 0; in_ready = 1 after release.
REQ-029 Reset mid-operation SHALL drop all in-flight results; no output for them after release.

Structure
REQ-030 SHALL place round-mode encodings, the flag bit indices and a width-derivation function in shared package fp_pkg.
REQ-031 SHALL instantiate one sub-module fp_lzc (parametrised leading-zero counter, width MAN_W+2, combinational).

Verification (EXP_W=8, MAN_W=23)
REQ-032 exp=127, hidden=1, frac=0, GRS=100, RNE -> 0x3F800000, flags inexact only.
REQ-033 exp=127, frac=0x000001, GRS=100, RNE -> 0x3F800002; same, RTZ -> 0x3F800001.
REQ-034 exp=254, carry=1, sign=0: RNE -> 0x7F800000, RTZ -> 0x7F7FFFFF, both overflow=1.
REQ-035 exp=3, leading one 5 positions below hidden -> 0x00000000 with sign kept, underflow=1, zero=1.
REQ-036 4 back-to-back inputs, out_ready low cycles 2-4 -> in_ready drops, all 4 results delivered in order, none lost or duplicated.
REQ-037 rst_n pulsed low with 2 results in flight -> out_valid 0 same cycle, no result after release, next input appears 2 cycles after transfer.
